// File: rtl/scope_dcsr_trace_pkg.sv
// Shared types and helpers for the multi-hart dcsr debug-entry trace block.
// The snapshot field order matches the low bits of a FIFO entry.
package scope_dcsr_trace_pkg;

  localparam logic [2:0] EBREAK       = 3'd1;
  localparam logic [2:0] TRIGGER      = 3'd2;
  localparam logic [2:0] HALTREQ      = 3'd3;
  localparam logic [2:0] STEP         = 3'd4;
  localparam logic [2:0] RESETHALTREQ = 3'd5;

  typedef struct packed {
    logic [2:0] cause;
    logic [1:0] prv;
    logic       step;
    logic [2:0] ebreak;  // {ebreakm, ebreaks, ebreaku}
  } dcsr_snap_t;

  localparam int SNAP_W = $bits(dcsr_snap_t);

  // A single-hart build still carries a 1-bit hart_id.
  function automatic int hart_id_w(input int n_harts);
    return (n_harts > 1) ? $clog2(n_harts) : 1;
  endfunction

  function automatic int entry_w(input int n_harts, input int ts_w);
    return hart_id_w(n_harts) + ts_w + SNAP_W;
  endfunction

endpackage

// File: rtl/scope_dcsr_trace_if.sv
// Valid/ready drain port carrying trace entries toward the debug/trace sink.
interface scope_dcsr_trace_if #(
  parameter int ENTRY_W = 14
);
  logic               out_valid;
  logic               out_ready;
  logic [ENTRY_W-1:0] out_entry;

  modport master (output out_valid, output out_entry, input  out_ready);
  modport slave  (input  out_valid, input  out_entry, output out_ready);
endinterface

// File: rtl/scope_dcsr_trace_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO; pointers carry one extra wrap bit.
// Head data reads as zero while empty.
module scope_dcsr_trace_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; empty gates dout, so stale
  // words are never visible and the array can map onto plain flops or RAM.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/scope_dcsr_trace.sv
// Multi-hart dcsr debug-entry tracer: per-hart hold registers, round-robin arbiter,
// shared FIFO, timestamp and saturating drop counter. Option: SCOPE_DCSR_TRACE_FILTER_EN.
module scope_dcsr_trace
  import scope_dcsr_trace_pkg::*;
#(
  parameter  int N_HARTS = 2,
  parameter  int DEPTH   = 8,
  parameter  int TS_W    = 16,
  parameter  int DROP_W  = 8,
  localparam int HID_W   = hart_id_w(N_HARTS),
  localparam int ENTRY_W = entry_w(N_HARTS, TS_W),
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N_HARTS-1:0]   evt_valid,
  input  logic [N_HARTS*2-1:0] evt_prv,
  input  logic [N_HARTS*3-1:0] evt_cause,
  input  logic [N_HARTS-1:0]   evt_step,
  input  logic [N_HARTS*3-1:0] evt_ebreak,
  input  logic                 ts_stop,
`ifdef SCOPE_DCSR_TRACE_FILTER_EN
  input  logic [7:0]           cause_mask,
`endif
  scope_dcsr_trace_if.master   out,
  output logic [DROP_W-1:0]    drop_cnt,
  output logic [LVL_W-1:0]     fifo_level
);

  typedef struct packed {
    logic [TS_W-1:0] ts;
    dcsr_snap_t      snap;
  } hold_t;

  localparam int                CNT_W    = DROP_W + 5;
  localparam logic [CNT_W-1:0]  DROP_MAX = (CNT_W'(1) << DROP_W) - CNT_W'(1);

  logic [TS_W-1:0]    ts;
  logic [N_HARTS-1:0] hold_v;
  hold_t              hold_q [N_HARTS];
  logic [HID_W-1:0]   rr_ptr;

  logic [N_HARTS-1:0] evt_take;
  logic [N_HARTS-1:0] drop_vec;
  logic [N_HARTS-1:0] grant_vec;
  logic               grant_any;
  logic [HID_W-1:0]   grant_id;
  logic [ENTRY_W-1:0] grant_data;
  logic [4:0]         drop_inc;
  logic [CNT_W-1:0]   drop_sum;
  logic               fifo_full;
  logic               fifo_empty;

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= N_HARTS) ? s - N_HARTS : s;
  endfunction

  always_comb begin
    for (int h = 0; h < N_HARTS; h++) begin
`ifdef SCOPE_DCSR_TRACE_FILTER_EN
      evt_take[h] = evt_valid[h] && cause_mask[evt_cause[h*3 +: 3]];
`else
      evt_take[h] = evt_valid[h];
`endif
      drop_vec[h] = evt_take[h] && hold_v[h] && !grant_vec[h];
    end
  end

  // Round-robin search starting at rr_ptr; nothing is granted while the FIFO is full.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so no
    // path can leave a value unassigned and infer a latch.
    grant_any  = 1'b0;
    grant_id   = '0;
    grant_vec  = '0;
    grant_data = '0;
    for (int i = 0; i < N_HARTS; i++) begin
      if (!grant_any && !fifo_full && hold_v[wrap_idx(int'(rr_ptr), i)]) begin
        grant_any  = 1'b1;
        grant_id   = HID_W'(wrap_idx(int'(rr_ptr), i));
        grant_vec[wrap_idx(int'(rr_ptr), i)] = 1'b1;
        grant_data = {HID_W'(wrap_idx(int'(rr_ptr), i)), hold_q[wrap_idx(int'(rr_ptr), i)]};
      end
    end
  end

  always_comb begin
    // NOTE: blocking '=' is right here: the sum is built up step by step within one
    // evaluation; registered state below only ever uses '<='.
    drop_inc = '0;
    for (int h = 0; h < N_HARTS; h++) drop_inc = drop_inc + 5'(drop_vec[h]);
    drop_sum = CNT_W'(drop_cnt) + CNT_W'(drop_inc);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ts       <= '0;
      drop_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      if (!ts_stop) ts <= ts + 1'b1;
      drop_cnt <= (drop_sum > DROP_MAX) ? DROP_W'(DROP_MAX) : DROP_W'(drop_sum);
      if (grant_any) rr_ptr <= (int'(grant_id) == N_HARTS - 1) ? '0 : grant_id + 1'b1;
    end
  end

  // A hold being granted this cycle is free to take a new event at the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_v <= '0;
      for (int h = 0; h < N_HARTS; h++) hold_q[h] <= '0;
    end else begin
      for (int h = 0; h < N_HARTS; h++) begin
        if (evt_take[h] && (!hold_v[h] || grant_vec[h])) begin
          hold_v[h]             <= 1'b1;
          hold_q[h].ts          <= ts;
          hold_q[h].snap.cause  <= evt_cause[h*3 +: 3];
          hold_q[h].snap.prv    <= evt_prv[h*2 +: 2];
          hold_q[h].snap.step   <= evt_step[h];
          hold_q[h].snap.ebreak <= evt_ebreak[h*3 +: 3];
        end else if (grant_vec[h]) begin
          hold_v[h] <= 1'b0;
        end
      end
    end
  end

  scope_dcsr_trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (grant_any),
    .din     (grant_data),
    .pop     (out.out_valid && out.out_ready),
    .dout    (out.out_entry),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out.out_valid = !fifo_empty;

endmodule

// File: tb/tb_scope_dcsr_trace.sv
// Scoreboard bench for scope_dcsr_trace: directed events queue expected entries,
// a negedge monitor pops and compares every accepted FIFO head.
module tb_scope_dcsr_trace;
  import scope_dcsr_trace_pkg::*;

  localparam int N_HARTS = 2;
  localparam int DEPTH   = 8;
  localparam int TS_W    = 4;
  localparam int DROP_W  = 8;
  localparam int HID_W   = hart_id_w(N_HARTS);
  localparam int ENTRY_W = entry_w(N_HARTS, TS_W);
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic [N_HARTS-1:0]   evt_valid = '0;
  logic [N_HARTS*2-1:0] evt_prv = '0;
  logic [N_HARTS*3-1:0] evt_cause = '0;
  logic [N_HARTS-1:0]   evt_step = '0;
  logic [N_HARTS*3-1:0] evt_ebreak = '0;
  logic                 ts_stop = 1'b0;
`ifdef SCOPE_DCSR_TRACE_FILTER_EN
  logic [7:0]           cause_mask = 8'hFF;
`endif
  logic [DROP_W-1:0]    drop_cnt;
  logic [LVL_W-1:0]     fifo_level;

  scope_dcsr_trace_if #(.ENTRY_W(ENTRY_W)) bus ();

  scope_dcsr_trace #(
    .N_HARTS (N_HARTS),
    .DEPTH   (DEPTH),
    .TS_W    (TS_W),
    .DROP_W  (DROP_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .evt_valid  (evt_valid),
    .evt_prv    (evt_prv),
    .evt_cause  (evt_cause),
    .evt_step   (evt_step),
    .evt_ebreak (evt_ebreak),
    .ts_stop    (ts_stop),
`ifdef SCOPE_DCSR_TRACE_FILTER_EN
    .cause_mask (cause_mask),
`endif
    .out        (bus),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level)
  );

  always #5 clock = ~clock;

  int                 checks = 0;
  int                 errors = 0;
  logic [ENTRY_W-1:0] exp_q [$];
  logic [ENTRY_W-1:0] mon_exp;
  logic [ENTRY_W-1:0] ev9;
  logic [ENTRY_W-1:0] ev_h1;
  logic [TS_W-1:0]    ts_m;

  // Reference timestamp: the value visible after an edge is what the next edge captures.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)     ts_m <= '0;
    else if (!ts_stop) ts_m <= ts_m + 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [ENTRY_W-1:0] mk(input int hid, input int ts, input int cause,
                                           input int prv, input int step, input int eb);
    return {HID_W'(hid), TS_W'(ts), 3'(cause), 2'(prv), 1'(step), 3'(eb)};
  endfunction

  always @(negedge clock) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_entry: got 0x%0h expected no entry", bus.out_entry);
      end else begin
        mon_exp = exp_q.pop_front();
        check("entry", 64'(bus.out_entry), 64'(mon_exp));
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    evt_valid     = '0;
    ts_stop       = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic set_evt(input int h, input int prv, input int cause, input int step, input int eb);
    evt_valid[h]          = 1'b1;
    evt_prv[h*2 +: 2]     = 2'(prv);
    evt_cause[h*3 +: 3]   = 3'(cause);
    evt_step[h]           = 1'(step);
    evt_ebreak[h*3 +: 3]  = 3'(eb);
  endtask

  task automatic wait_ts(input int v);
    int n = 0;
    while (ts_m != TS_W'(v) && n < 64) begin
      cyc();
      n++;
    end
    if (ts_m != TS_W'(v)) begin
      checks++;
      errors++;
      $display("FAIL wait_ts_timeout: got %0d expected %0d", ts_m, v);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    bus.out_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      cyc();
      n++;
    end
    check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    check({name, "_level"}, 64'(fifo_level), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state and minimum event-to-visibility latency.
    do_reset();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_entry", 64'(bus.out_entry), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_fifo_level", 64'(fifo_level), 64'd0);
    wait_ts(5);
    set_evt(0, 3, HALTREQ, 0, 0);
    exp_q.push_back(mk(0, 5, 3, 3, 0, 0));
    cyc();
    evt_valid = '0;
    check("lat_after_e0", 64'(bus.out_valid), 64'd0);
    cyc();
    check("lat_after_e1", 64'(bus.out_valid), 64'd1);
    check("lat_level", 64'(fifo_level), 64'd1);
    drain("t1");

    // Two harts in one cycle drain in round-robin order, twice.
    do_reset();
    bus.out_ready = 1'b1;
    set_evt(0, 0, EBREAK, 1, 3'b100);
    set_evt(1, 1, TRIGGER, 0, 3'b001);
    exp_q.push_back(mk(0, ts_m, 1, 0, 1, 4));
    exp_q.push_back(mk(1, ts_m, 2, 1, 0, 1));
    cyc();
    evt_valid = '0;
    drain("t2a");
    set_evt(0, 2, STEP, 0, 3'b010);
    set_evt(1, 3, HALTREQ, 1, 3'b110);
    exp_q.push_back(mk(0, ts_m, 4, 2, 0, 2));
    exp_q.push_back(mk(1, ts_m, 3, 3, 1, 6));
    cyc();
    evt_valid = '0;
    drain("t2b");
    check("t2_drop_cnt", 64'(drop_cnt), 64'd0);

    // Back-pressure: ten hart0 events fill the FIFO and the hold, the tenth drops.
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      set_evt(0, k % 4, k % 8, k % 2, (k * 3) % 8);
      if (k <= 8)       exp_q.push_back(mk(0, ts_m, k % 8, k % 4, k % 2, (k * 3) % 8));
      else if (k == 9)  ev9 = mk(0, ts_m, k % 8, k % 4, k % 2, (k * 3) % 8);
      cyc();
    end
    evt_valid = '0;
    check("full_level", 64'(fifo_level), 64'd8);
    check("full_drop_cnt", 64'(drop_cnt), 64'd1);
    set_evt(1, 1, HALTREQ, 0, 3'b010);
    ev_h1 = mk(1, ts_m, 3, 1, 0, 2);
    cyc();
    evt_valid = '0;
    check("free_hold_no_drop", 64'(drop_cnt), 64'd1);
    set_evt(0, 0, EBREAK, 0, 0);
    set_evt(1, 0, EBREAK, 0, 0);
    cyc();
    evt_valid = '0;
    check("popcount_drops", 64'(drop_cnt), 64'd3);
    set_evt(0, 0, EBREAK, 0, 0);
    set_evt(1, 0, EBREAK, 0, 0);
    repeat (130) cyc();
    evt_valid = '0;
    check("drop_saturate", 64'(drop_cnt), 64'd255);
    // rr pointer sits on hart1 after the hart0 grants, so hart1 goes first.
    exp_q.push_back(ev_h1);
    exp_q.push_back(ev9);

    // Full with a pop and a valid hold: pop only, push on the following edge.
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    check("full_pop_level", 64'(fifo_level), 64'd7);
    cyc();
    check("refill_level", 64'(fifo_level), 64'd8);
    drain("t4");
    check("drop_held", 64'(drop_cnt), 64'd255);

    // Reset mid-operation discards buffered entries and clears the drop count.
    bus.out_ready = 1'b0;
    set_evt(0, 1, STEP, 1, 1);
    cyc();
    evt_valid = '0;
    cyc();
    cyc();
    check("pre_reset_level", 64'(fifo_level), 64'd1);
    do_reset();
    check("midrst_level", 64'(fifo_level), 64'd0);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_drop_cnt", 64'(drop_cnt), 64'd0);

    // Timestamp freeze during ts_stop, then wrap 15 -> 0.
    bus.out_ready = 1'b1;
    wait_ts(13);
    ts_stop = 1'b1;
    cyc();
    set_evt(1, 1, STEP, 1, 3'b101);
    exp_q.push_back(mk(1, 13, 4, 1, 1, 5));
    cyc();
    evt_valid = '0;
    cyc();
    cyc();
    ts_stop = 1'b0;
    wait_ts(15);
    set_evt(0, 3, EBREAK, 0, 3'b111);
    exp_q.push_back(mk(0, 15, 1, 3, 0, 7));
    cyc();
    evt_valid = '0;
    set_evt(1, 0, RESETHALTREQ, 0, 3'b010);
    exp_q.push_back(mk(1, 0, 5, 0, 0, 2));
    cyc();
    evt_valid = '0;
    drain("t5");

`ifdef SCOPE_DCSR_TRACE_FILTER_EN
    // Cause filter: only cause 4 passes; masked events neither capture nor drop.
    do_reset();
    cause_mask    = 8'b0001_0000;
    bus.out_ready = 1'b1;
    set_evt(0, 3, STEP, 0, 0);
    set_evt(1, 3, EBREAK, 0, 0);
    exp_q.push_back(mk(0, ts_m, 4, 3, 0, 0));
    cyc();
    evt_valid = '0;
    set_evt(0, 2, EBREAK, 1, 3'b001);
    cyc();
    evt_valid = '0;
    drain("t6");
    check("filter_drop_cnt", 64'(drop_cnt), 64'd0);
    cause_mask = 8'hFF;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scope_dcsr_trace.md
Name: scope_dcsr_trace

Overview:
Multi-hart successor to the per-hart dcsr scope bundle. On each hart's debug-entry event it snapshots that hart's dcsr fields (prv, cause, step, ebreak enables) with a timestamp. Snapshots are buffered in a shared FIFO and drained over a valid/ready port toward the debug/trace sink. It sits beside the debug module, between the cores' dcsr outputs and the scope readout logic.

Parameters:
N_HARTS, 2, number of hart channels (1..16)
DEPTH, 8, FIFO entries (power of two, >=2)
TS_W, 16, timestamp counter width
DROP_W, 8, width of the saturating drop counter

Ports:
clock  in  1  block clock
reset_n  in  1  asynchronous active-low reset
evt_valid  in  N_HARTS  per-hart debug-entry pulse, one bit per hart
evt_prv  in  N_HARTS*2  dcsr.prv per hart
evt_cause  in  N_HARTS*3  dcsr.cause per hart
evt_step  in  N_HARTS  dcsr.step per hart
evt_ebreak  in  N_HARTS*3  {ebreakm, ebreaks, ebreaku} per hart
ts_stop  in  1  freeze timestamp (dcsr.stoptime aggregate)
out_valid  out  1  FIFO head valid
out_ready  in  1  sink accepts head
out_entry  out  ENTRY_W  {hart_id, ts, cause, prv, step, ebreak[2:0]}; ENTRY_W = clog2(N_HARTS)+TS_W+9, min hart_id width 1
drop_cnt  out  DROP_W  saturating count of lost events
fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync deassert is external): FIFO empty, out_valid=0, out_entry=0, drop_cnt=0, fifo_level=0, ts=0, all hold registers invalid, RR pointer=0.
- Timestamp: free-running TS_W counter. +1 per cycle unless ts_stop=1. Wraps from all-ones to 0 with no flag.
- Capture stage: per-hart single-entry hold register.
  - evt_valid[h]=1 at edge E0 with hold[h] empty, or being granted that same cycle: latch fields plus the current ts. Hold valid after E0.
  - evt_valid[h]=1 while hold[h] is valid and not granted that cycle: event dropped, drop_cnt +1, saturating at all-ones.
  - Multiple harts dropping in one cycle add the number of drops (popcount), saturating.
- Arbiter: round-robin over valid holds; at most one grant per cycle, and only when the FIFO is not full (registered level < DEPTH).
  - After a grant to hart g, the priority pointer moves to g+1 mod N_HARTS.
  - Granted hold clears at the edge; the entry is written to the FIFO at that same edge.
- FIFO: DEPTH entries, read/write pointers one bit wider than the address.
  - out_valid = level != 0; out_entry driven from the head register (zero when empty).
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle: level unchanged.
  - Full: no grant, even if a pop occurs that cycle (no push-through-full).
- Latency: event at E0 -> hold valid after E0 -> earliest FIFO write at E1 -> out_valid high after E1. Minimum 2 edges from event to visibility.
- Reset mid-operation: all held and buffered entries are discarded, and drop_cnt is cleared.
- Entry hart_id is the granted index. cause is stored unmodified (values 0..7 permitted).

Optional Feature:
SCOPE_DCSR_TRACE_FILTER_EN
- Defined: adds input cause_mask[7:0]. An event whose cause bit is clear in cause_mask is ignored: not captured and not counted as a drop. Mask is sampled in the event cycle.
- Undefined: port absent; all causes are captured.

Decomposition:
- Package scope_dcsr_trace_pkg holds:
  - dcsr cause localparams (EBREAK=1, TRIGGER=2, HALTREQ=3, STEP=4, RESETHALTREQ=5)
  - packed struct typedef for the dcsr snapshot (prv, step, cause, ebreak bits)
  - function computing ENTRY_W
- One sub-module: scope_dcsr_trace_fifo, a generic DEPTH x WIDTH synchronous FIFO with level, full and empty.
- Hold registers, arbiter, timestamp and drop counter live in the top.

Test Plan:
1. Reset, then hart0 evt cause=3 prv=3 at ts=5 -> out_valid rises 2 edges later; entry hart_id=0, ts=5, cause=3, prv=3.
2. Harts 0 and 1 fire in the same cycle, out_ready=1 -> entries drain as hart0 then hart1. Repeat once more -> hart1 is not starved; RR pointer order holds.
3. out_ready=0, hart0 fires 10 times with DEPTH=8 and N_HARTS=2 -> fifo_level=8, one entry in hold, drop_cnt=1; remaining events counted as drops.
4. FIFO full with out_ready=1 and hold valid in the same cycle -> pop occurs, no push that cycle; push on the following edge; level goes 8->7->8.
5. ts_stop=1 for 4 cycles with an event during the stop, then TS wrap (TS_W=4, 15->0) -> captured ts is frozen at the stop value; wraps to 0 with no error.
6. With SCOPE_DCSR_TRACE_FILTER_EN and cause_mask=8'b0001_0000 -> cause=4 events are captured, cause=1 events are ignored, drop_cnt stays 0.
